regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_pkg.sv | 18 +
 rtl/regfile_rd_port.sv | 42 ++++
 rtl/regfile_mp.sv | 132 +++++++++++++
 tb/tb_regfile_mp.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-ported register file.
// Holds the control-level constants (reset/enable polarity, zero word) and
// the FSM state encoding used by regfile_mp and its read-port sub-module.
package regfile_mp_pkg;

  // Control polarities and the cleared-entry value.
  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic        ReadEnable  = 1'b1;
  localparam int unsigned ZeroWord    = 0;

  // Clear-sweep FSM encoding.
  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of regfile_mp.
// Returns zero when disabled or addressing entry 0; otherwise forwards the
// data of any write port hitting the same address this cycle (highest index
// wins), falling back to the stored entry.
// Ports:
//   en_i       - read port enabled and file in RUN
//   raddr_i    - read address
//   we_i       - qualified write enables (RUN, nonzero address)
//   waddr_i    - packed write addresses, port k in slice k
//   wdata_i    - packed write data, port k in slice k
//   mem_data_i - stored entry at raddr_i
//   rdata_o    - read result
module regfile_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NWR    = 2
) (
  input  logic                  en_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  input  logic [NWR-1:0]        we_i,
  input  logic [NWR*ADDR_W-1:0] waddr_i,
  input  logic [NWR*DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0]     mem_data_i,
  output logic [DATA_W-1:0]     rdata_o
);

  always_comb begin
    rdata_o = DATA_W'(ZeroWord);
    if (en_i && (raddr_i != '0)) begin
      rdata_o = mem_data_i;
      // Ascending loop so the highest-index matching write port wins.
      for (int k = 0; k < int'(NWR); k++) begin
        if (we_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] == raddr_i)) begin
          rdata_o = wdata_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with a post-reset clear sweep.
// After reset the FSM walks every entry writing zero, one per cycle, so the
// storage itself needs no reset. Entry 0 is hard-wired to read as zero.
// Ports:
//   clk         - clock, all state on rising edge
//   rst         - synchronous active-high reset, restarts the sweep
//   we          - per write port enable
//   waddr       - packed write addresses
//   wdata       - packed write data
//   re          - per read port enable
//   raddr       - packed read addresses
//   rdata       - packed combinational read data
//   init_busy   - clear sweep in progress
//   wr_conflict - one-cycle flag after a same-address double write
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic                  init_busy,
  output logic                  wr_conflict
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                wr_conflict_q, wr_conflict_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                run;
  logic                clear_en;
  logic [NWR-1:0]      we_eff;

  // A reset in RUN must gate reads and writes before the state register updates.
  assign run      = (state_q == StRun) && (rst != RstEnable);
  assign clear_en = (state_q == StInit) && (rst != RstEnable);

  // Sweep FSM next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst == RstEnable) begin
      state_d = StInit;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StInit: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
        StRun: begin
          state_d = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    cnt_q         <= cnt_d;
    wr_conflict_q <= wr_conflict_d;
  end

  // Writes to address 0 are dropped so entry 0 keeps its cleared value.
  always_comb begin
    we_eff = '0;
    for (int k = 0; k < int'(NWR); k++) begin
      we_eff[k] = run && (we[k] == WriteEnable) && (waddr[k*ADDR_W +: ADDR_W] != '0);
    end
  end

  generate
    if (NWR >= 2) begin : g_conflict
      assign wr_conflict_d = we_eff[0] && we_eff[1] &&
                             (waddr[0 +: ADDR_W] == waddr[ADDR_W +: ADDR_W]);
    end else begin : g_no_conflict
      assign wr_conflict_d = 1'b0;
    end
  endgenerate

  // Storage: sweep clear and port writes are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem_q[cnt_q] <= DATA_W'(ZeroWord);
    end
    // Later ports overwrite earlier ones, so port 1 wins a collision.
    for (int k = 0; k < int'(NWR); k++) begin
      if (we_eff[k]) begin
        mem_q[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  generate
    for (genvar j = 0; j < int'(NRD); j++) begin : g_rd
      logic [DATA_W-1:0] mem_rd;
      assign mem_rd = mem_q[raddr[j*ADDR_W +: ADDR_W]];

      regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NWR    (NWR)
      ) u_rd_port (
        .en_i       (run && (re[j] == ReadEnable)),
        .raddr_i    (raddr[j*ADDR_W +: ADDR_W]),
        .we_i       (we_eff),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .mem_data_i (mem_rd),
        .rdata_o    (rdata[j*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign init_busy   = (state_q == StInit) || (rst == RstEnable);
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int DEP = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NWR-1:0]    we;
  logic [NWR*AW-1:0] waddr;
  logic [NWR*DW-1:0] wdata;
  logic [NRD-1:0]    re;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic              init_busy;
  logic              wr_conflict;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W (DW),
    .DEPTH  (DEP),
    .ADDR_W (AW),
    .NRD    (NRD),
    .NWR    (NWR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .re          (re),
    .raddr       (raddr),
    .rdata       (rdata),
    .init_busy   (init_busy),
    .wr_conflict (wr_conflict)
  );

  typedef struct {
    string       tag;
    int          port;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input int port, input logic [DW-1:0] e);
    exp_t x;
    x.tag  = tag;
    x.port = port;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, rdata[e.port*DW +: DW], e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we    = '0;
    re    = '0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[k]             = 1'b1;
    waddr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic rd(input int j, input logic [AW-1:0] a);
    re[j]             = 1'b1;
    raddr[j*AW +: AW] = a;
  endtask

  // Called at posedge+2 while sweeping; counts edges until init_busy drops.
  task automatic measure_sweep(input string tag);
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      step();
      #1;
      n++;
    end
    chk(tag, DW'(n), DW'(DEP));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    rd(0, 5'd5);
    rd(1, 5'd9);
    repeat (3) begin
      step();
      #1;
      chk("rst_busy", DW'(init_busy), 32'd1);
      chk("rst_confl", DW'(wr_conflict), 32'd0);
      push("rst_rd0", 0, 32'h0);
      push("rst_rd1", 1, 32'h0);
      drain();
    end

    // Release reset; a write attempted during the sweep must be ignored.
    step();
    rst = 1'b0;
    wr(0, 5'd3, 32'h0000_00AA);
    rd(0, 5'd3);
    #1;
    push("init_rd0", 0, 32'h0);
    drain();
    measure_sweep("sweep_len");
    idle();
    chk("run_busy", DW'(init_busy), 32'd0);

    for (int a = 0; a < DEP; a++) begin
      step();
      rd(0, AW'(a));
      rd(1, AW'(DEP - 1 - a));
      #1;
      push($sformatf("clr_p0_a%0d", a), 0, 32'h0);
      push($sformatf("clr_p1_a%0d", DEP - 1 - a), 1, 32'h0);
      drain();
    end

    // Write then read, with same-cycle bypass.
    step();
    idle();
    wr(0, 5'd5, 32'hDEAD_BEEF);
    rd(0, 5'd5);
    rd(1, 5'd6);
    #1;
    push("byp_5", 0, 32'hDEAD_BEEF);
    push("byp_other", 1, 32'h0);
    drain();
    step();
    idle();
    rd(0, 5'd5);
    rd(1, 5'd5);
    #1;
    push("stored_5_p0", 0, 32'hDEAD_BEEF);
    push("stored_5_p1", 1, 32'hDEAD_BEEF);
    drain();
    chk("no_confl", DW'(wr_conflict), 32'd0);

    // Collision at address 7: port 1 wins, flag for one cycle.
    step();
    idle();
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    rd(0, 5'd7);
    rd(1, 5'd7);
    #1;
    push("coll_byp0", 0, 32'h22);
    push("coll_byp1", 1, 32'h22);
    drain();
    chk("coll_flag_pre", DW'(wr_conflict), 32'd0);
    step();
    idle();
    rd(0, 5'd7);
    #1;
    push("coll_stored", 0, 32'h22);
    drain();
    chk("coll_flag", DW'(wr_conflict), 32'd1);
    step();
    #1;
    chk("coll_flag_clr", DW'(wr_conflict), 32'd0);

    // Different-address writes: each read port bypasses its own port.
    idle();
    wr(0, 5'd9, 32'h99);
    wr(1, 5'd10, 32'h1010);
    rd(0, 5'd9);
    rd(1, 5'd10);
    #1;
    push("byp_p0_9", 0, 32'h99);
    push("byp_p1_10", 1, 32'h1010);
    drain();
    step();
    idle();
    rd(0, 5'd10);
    rd(1, 5'd9);
    #1;
    push("stored_10", 0, 32'h1010);
    push("stored_9", 1, 32'h99);
    drain();
    chk("diff_no_confl", DW'(wr_conflict), 32'd0);

    // Address 0 is never written and never flags a conflict.
    step();
    idle();
    wr(0, 5'd0, 32'hFFFF_FFFF);
    wr(1, 5'd0, 32'hFFFF_FFFF);
    rd(0, 5'd0);
    rd(1, 5'd0);
    #1;
    push("a0_byp0", 0, 32'h0);
    push("a0_byp1", 1, 32'h0);
    drain();
    step();
    idle();
    rd(0, 5'd0);
    #1;
    push("a0_stored", 0, 32'h0);
    drain();
    chk("a0_confl", DW'(wr_conflict), 32'd0);

    // Read enable gating on port 1.
    step();
    idle();
    rd(0, 5'd5);
    raddr[AW +: AW] = 5'd5;
    #1;
    push("re_on_p0", 0, 32'hDEAD_BEEF);
    push("re_off_p1", 1, 32'h0);
    drain();

    // Reset in RUN gates reads immediately, then reset again mid-sweep.
    step();
    rst = 1'b1;
    #1;
    push("rst_run_rd0", 0, 32'h0);
    drain();
    chk("rst_run_busy", DW'(init_busy), 32'd1);
    step();
    rst = 1'b0;
    idle();
    repeat (10) step();
    #1;
    chk("mid_busy", DW'(init_busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    measure_sweep("resweep_len");
    idle();
    rd(0, 5'd5);
    rd(1, 5'd7);
    #1;
    push("resweep_5", 0, 32'h0);
    push("resweep_7", 1, 32'h0);
    drain();
    chk("resweep_confl", DW'(wr_conflict), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
